stack_arbiter: RTL and testbench

STACK_ARBITER -- requirements
Module: stack_arbiter

---
 rtl/stack_arbiter.sv | 144 ++++++++++++++
 tb/tb_stack_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_arbiter.sv
// rtl/stack_arbiter.sv - round-robin push/pop arbiter in front of a shared stack, with flush drain
// Defining STACK_ARBITER_STATS_EN adds saturating push/pop/stall counters.
module stack_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_push,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_data,
  input  logic                     flush,
  output logic                     flush_done,
  output logic                     stk_push,
  output logic                     stk_pop,
  output logic [WIDTH-1:0]         stk_data_in,
  input  logic [WIDTH-1:0]         stk_data_out,
  input  logic                     stk_empty,
  input  logic                     stk_full
`ifdef STACK_ARBITER_STATS_EN
  ,
  output logic [31:0]              push_count,
  output logic [31:0]              pop_count,
  output logic [31:0]              stall_count
`endif
);

  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t          state, state_next;
  logic [PW-1:0]   ptr;
  logic [NUM_REQ-1:0] eligible;
  logic            grant_found;
  logic            grant_push;
  logic [PW-1:0]   grant_idx;
  logic [PW-1:0]   cand_idx;
  int              cand;
  logic            flush_done_next;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] & (req_push[i] ? !stk_full : !stk_empty);
    end
  end

  // Search starts one above the last winner so every requester gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = ptr;
    cand        = 0;
    cand_idx    = '0;
    if (state == RUN) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand = int'(ptr) + k;
        if (cand >= NUM_REQ) cand = cand - NUM_REQ;
        cand_idx = PW'(cand);
        if (!grant_found && eligible[cand_idx]) begin
          grant_found = 1'b1;
          grant_idx   = cand_idx;
        end
      end
    end
  end

  assign grant_push = req_push[grant_idx];

  always_comb begin
    state_next      = state;
    req_ready       = '0;
    stk_push        = 1'b0;
    stk_pop         = 1'b0;
    flush_done_next = 1'b0;
    case (state)
      RUN: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          stk_push             = grant_push;
          stk_pop              = !grant_push;
        end
        if (flush) state_next = FLUSH;
      end
      FLUSH: begin
        if (!stk_empty) begin
          stk_pop = 1'b1;
        end else begin
          flush_done_next = 1'b1;
          state_next      = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    stk_data_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == PW'(i)) stk_data_in = req_data[i*WIDTH +: WIDTH];
    end
  end

  // Flush pops also raise stk_pop, so responses are tied to granted pops only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RUN;
      ptr        <= PW'(NUM_REQ - 1);
      rsp_valid  <= '0;
      rsp_data   <= '0;
      flush_done <= 1'b0;
    end else begin
      state      <= state_next;
      flush_done <= flush_done_next;
      rsp_valid  <= '0;
      if (grant_found) begin
        ptr <= grant_idx;
        if (!grant_push) begin
          rsp_valid <= req_ready;
          rsp_data  <= stk_data_out;
        end
      end
    end
  end

`ifdef STACK_ARBITER_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      push_count  <= '0;
      pop_count   <= '0;
      stall_count <= '0;
    end else begin
      if (grant_found && grant_push && push_count != '1) push_count <= push_count + 32'd1;
      if (grant_found && !grant_push && pop_count != '1) pop_count <= pop_count + 32'd1;
      if (state == RUN && (|req_valid) && !grant_found && stall_count != '1)
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stack_arbiter.sv
// tb/tb_stack_arbiter.sv - self-checking bench for stack_arbiter driving a depth-4 stack model
module tb_stack_arbiter;
  localparam int W = 32, N = 4, DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic [N-1:0]   req_valid, req_push, req_ready, rsp_valid;
  logic [N*W-1:0] req_data;
  logic [W-1:0]   rsp_data, stk_data_in, stk_data_out;
  logic flush, flush_done, stk_push, stk_pop, stk_empty, stk_full;
`ifdef STACK_ARBITER_STATS_EN
  logic [31:0] push_count, pop_count, stall_count;
`endif

  int checks = 0, failures = 0, blocked = 0;

  always #5 clk = ~clk;

  stack_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_push(req_push), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .flush(flush), .flush_done(flush_done),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_data_in(stk_data_in),
    .stk_data_out(stk_data_out), .stk_empty(stk_empty), .stk_full(stk_full)
`ifdef STACK_ARBITER_STATS_EN
    , .push_count(push_count), .pop_count(pop_count), .stall_count(stall_count)
`endif
  );

  // Stack seen by the DUT; ov lets the vector table force the status flags directly.
  logic ov = 1'b0, ov_empty = 1'b1, ov_full = 1'b0;
  logic [W-1:0] ov_dout = '0;
  logic [W-1:0] mem [DEPTH];
  int cnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= 0;
    else if (!ov) begin
      if (stk_push && cnt < DEPTH) begin mem[2'(cnt)] <= stk_data_in; cnt <= cnt + 1; end
      else if (stk_pop && cnt > 0) cnt <= cnt - 1;
    end
  end
  assign stk_empty    = ov ? ov_empty : (cnt == 0);
  assign stk_full     = ov ? ov_full : (cnt == DEPTH);
  assign stk_data_out = ov ? ov_dout : ((cnt > 0) ? mem[2'(cnt - 1)] : '0);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: stack contents as a queue, last winner as an index.
  logic chk_en = 1'b0;
  logic [W-1:0] ref_q[$];
  int m_last = N - 1;
  bit m_flushing = 0, m_fd = 0;
  logic [N-1:0] m_rsp_v = '0;
  logic [W-1:0] m_rsp_d = '0;

  task automatic model_cycle();
    logic [N-1:0] e_ready, n_rsp_v;
    logic e_push, e_pop, n_fd;
    logic [W-1:0] e_din;
    int g;
    e_ready = '0; n_rsp_v = '0; e_push = 0; e_pop = 0; n_fd = 0; e_din = '0; g = -1;
    check("rsp_valid", rsp_valid, m_rsp_v);
    check("rsp_data", rsp_data, m_rsp_d);
    check("flush_done", flush_done, m_fd);
    if (m_flushing) begin
      if (ref_q.size() > 0) begin e_pop = 1; void'(ref_q.pop_back()); end
      else begin n_fd = 1; m_flushing = 0; end
    end else begin
      for (int k = 1; k <= N && g < 0; k++) begin
        int i;
        i = (m_last + k) % N;
        if (req_valid[i] && (req_push[i] ? ref_q.size() < DEPTH : ref_q.size() > 0)) g = i;
      end
      if (g >= 0) begin
        e_ready[g] = 1'b1;
        m_last = g;
        if (req_push[g]) begin
          e_push = 1; e_din = req_data[g*W +: W]; ref_q.push_back(e_din);
        end else begin
          e_pop = 1; n_rsp_v[g] = 1'b1; m_rsp_d = ref_q.pop_back();
        end
      end
      if (flush) m_flushing = 1;
    end
    check("req_ready", req_ready, e_ready);
    check("stk_push", stk_push, e_push);
    check("stk_pop", stk_pop, e_pop);
    if (e_push) check("stk_data_in", stk_data_in, e_din);
    m_rsp_v = n_rsp_v;
    m_fd = n_fd;
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      ref_q.delete(); m_last = N - 1; m_flushing = 0; m_rsp_v = '0; m_rsp_d = '0; m_fd = 0;
    end else if (chk_en) begin
      model_cycle();
    end
  end

  task automatic set_req(input int i, input logic push, input logic [W-1:0] d);
    req_valid[i] = 1'b1;
    req_push[i]  = push;
    req_data[i*W +: W] = d;
  endtask

  // One clock: sample acceptance on the falling edge, retire accepted requests after the rise.
  task automatic step(output logic [N-1:0] acc);
    @(negedge clk);
    acc = req_valid & req_ready;
    if (reset_n && (|req_valid) && req_ready == '0) blocked++;
    @(posedge clk); #1;
    req_valid = req_valid & ~acc;
    flush = 1'b0;
  endtask

  task automatic do_reset();
    req_valid = '0; flush = 1'b0; reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0] valid, push;
    logic empty, full;
    logic [N-1:0] ready;
    logic spush, spop;
  } vec_t;
  vec_t tbl[10];

  initial begin
    logic [N-1:0] acc;
    int order[$], gcyc[$], rcyc[$];
    logic [W-1:0] rdat[$];
    int ncyc, npop, nrsp, fd_at, ready_bad, pop_first, pop_last;

    tbl[0] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[1] = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b0};
    tbl[2] = '{4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0};
    tbl[3] = '{4'b1111, 4'b1111, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0};
    tbl[4] = '{4'b1111, 4'b0000, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b1};
    tbl[5] = '{4'b0011, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[6] = '{4'b0011, 4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b0};
    tbl[7] = '{4'b1010, 4'b1000, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b1};
    tbl[8] = '{4'b1001, 4'b1001, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b0};
    tbl[9] = '{4'b1001, 4'b1001, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0};

    req_valid = '0; req_push = '0; req_data = '0; flush = 1'b0;
    reset_n = 1'b0;
    #12;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_flush_done", flush_done, 0);
    check("reset_req_ready", req_ready, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    ov = 1'b1;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 32'h100 + i;
    for (int v = 0; v < 10; v++) begin
      req_valid = tbl[v].valid; req_push = tbl[v].push;
      ov_empty = tbl[v].empty; ov_full = tbl[v].full;
      @(negedge clk);
      check($sformatf("tbl%0d_ready", v), req_ready, tbl[v].ready);
      check($sformatf("tbl%0d_stk_push", v), stk_push, tbl[v].spush);
      check($sformatf("tbl%0d_stk_pop", v), stk_pop, tbl[v].spop);
      if (tbl[v].spush) check($sformatf("tbl%0d_data", v), stk_data_in, 32'h100 + $clog2(tbl[v].ready));
      @(posedge clk); #1;
    end
    req_valid = '0;
    ov = 1'b0;
    do_reset();
    blocked = 0;
    chk_en = 1'b1;

    for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'hA0 + i);
    ncyc = 0;
    for (int c = 0; c < 8 && req_valid != '0; c++) begin
      step(acc);
      ncyc++;
      for (int i = 0; i < N; i++) if (acc[i]) order.push_back(i);
    end
    check("r036_grants", order.size(), 4);
    check("r036_cycles", ncyc, 4);
    for (int i = 0; i < 4; i++) check($sformatf("r036_order%0d", i), (order.size() > i) ? order[i] : -1, i);
    @(negedge clk);
    check("r036_full", stk_full, 1);
    @(posedge clk); #1;

    set_req(2, 1'b0, '0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        rcyc.push_back(c); rdat.push_back(rsp_data);
        check("r037_rsp_onehot", rsp_valid, 4'b0100);
      end
      acc = req_valid & req_ready;
      if (acc[2]) gcyc.push_back(c);
      @(posedge clk); #1;
      if (gcyc.size() == 4) req_valid[2] = 1'b0;
    end
    check("r037_grants", gcyc.size(), 4);
    check("r037_rsps", rcyc.size(), 4);
    for (int k = 0; k < 4 && k < rcyc.size() && k < gcyc.size(); k++) begin
      check($sformatf("r037_latency%0d", k), rcyc[k] - gcyc[k], 1);
      check($sformatf("r037_data%0d", k), rdat[k], 32'hA3 - k);
    end

    set_req(1, 1'b0, '0);
    for (int c = 0; c < 3; c++) begin
      step(acc);
      check("r038_pop_blocked", acc, 0);
    end
    set_req(0, 1'b1, 32'h55);
    step(acc);
    check("r038_push_grant", acc, 4'b0001);
    step(acc);
    check("r038_pop_grant", acc, 4'b0010);
    @(negedge clk);
    check("r038_rsp_valid", rsp_valid, 4'b0010);
    check("r038_rsp_data", rsp_data, 32'h55);
    @(posedge clk); #1;
`ifdef STACK_ARBITER_STATS_EN
    check("stats_push_count", push_count, 5);
    check("stats_pop_count", pop_count, 5);
    check("stats_stall_count", stall_count, blocked);
`endif

    for (int k = 0; k < 3; k++) begin
      set_req(3, 1'b1, 32'h11 * (k + 1));
      step(acc);
      check("r039_fill", acc, 4'b1000);
    end
    flush = 1'b1;
    step(acc);
    set_req(0, 1'b1, 32'h77);
    set_req(1, 1'b0, '0);
    npop = 0; nrsp = 0; fd_at = -1; ready_bad = 0; pop_first = -1; pop_last = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c <= 4 && stk_pop) begin
        npop++;
        if (pop_first < 0) pop_first = c;
        pop_last = c;
      end
      if (c <= 4 && rsp_valid != '0) nrsp++;
      if (c <= 4 && req_ready != '0) ready_bad++;
      if (flush_done && fd_at < 0) fd_at = c;
      acc = req_valid & req_ready;
      if (c == 5) check("r039_grant_after_flush", acc, 4'b0001);
      @(posedge clk); #1;
      req_valid = req_valid & ~acc;
    end
    check("r039_pops", npop, 3);
    check("r039_pop_first", pop_first, 1);
    check("r039_pop_last", pop_last, 3);
    check("r039_no_rsp", nrsp, 0);
    check("r039_blocked", ready_bad, 0);
    check("r039_flush_done_cycle", fd_at, 5);
    req_valid = '0;

    set_req(0, 1'b1, 32'h99);
    step(acc);
    set_req(2, 1'b0, '0);
    @(negedge clk);
    acc = req_valid & req_ready;
    check("r040_pop_grant", acc, 4'b0100);
    #2 reset_n = 1'b0;
    #1;
    check("r040_async_rsp_data", rsp_data, 0);
    check("r040_async_rsp_valid", rsp_valid, 0);
    req_valid = '0;
    @(posedge clk); #1;
    check("r040_no_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    check("r040_post_rsp_valid", rsp_valid, 0);
    check("r040_post_rsp_data", rsp_data, 0);
    @(posedge clk); #1;
    set_req(0, 1'b1, 32'h1);
    set_req(2, 1'b1, 32'h2);
    step(acc);
    check("r040_first_grant", acc, 4'b0001);
    step(acc);
    check("r040_second_grant", acc, 4'b0100);

    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0) set_req(i, 1'($urandom_range(0, 1)), $urandom);
      flush = ($urandom_range(0, 19) == 0);
      step(acc);
    end
    req_valid = '0;
    repeat (8) step(acc);
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
